support_wb_sequencer: RTL

Sequences support-CPU I/O cycles onto the shared Wishbone peripheral bus (UART, interrupt manager, I2C, keyboard, USB host). Decodes port high nibble into a one-hot strobe, stalls the CPU via `wait_n_o` until the addressed peripheral acks or a timeout expires, and holds the read data until the I/O cycle ends. Replaces ad-hoc per-peripheral strobe shortening: every peripheral sees exactly one strobe burst per CPU I/O cycle.

---
 rtl/support_wb_sequencer_pkg.sv | 26 ++
 rtl/wb_timeout_counter.sv | 35 +++
 rtl/support_wb_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/support_wb_sequencer_pkg.sv
// Shared types and constants for the support-CPU Wishbone I/O sequencer:
// state encoding, strobe decode helper and reset values.
package support_io_pkg;

  localparam int STB_DEVICES = 16;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_STROBE   = 2'd2,
    ST_HOLD     = 2'd3
  } seq_state_t;

  localparam logic [7:0]             RST_DAT = 8'h00;
  localparam logic [7:0]             RST_ADR = 8'h00;
  localparam logic [STB_DEVICES-1:0] RST_STB = {STB_DEVICES{1'b0}};

  // One-hot peripheral select from the port address high nibble.
  function automatic logic [STB_DEVICES-1:0] stb_decode(input logic [3:0] nibble);
    logic [STB_DEVICES-1:0] onehot_s;
    onehot_s         = {STB_DEVICES{1'b0}};
    onehot_s[nibble] = 1'b1;
    return onehot_s;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Strobe-phase watchdog: cleared when a strobe starts, counts strobe cycles,
// saturates, and flags the last permitted strobe cycle.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_r;

  // Strobe cycle counter, held at its ceiling instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= ZERO;
    end else if (clr_i) begin
      count_r <= ZERO;
    end else if (en_i && (count_r != SAT)) begin
      count_r <= count_r + ONE;
    end
  end

  // The counter holds strobe cycles already completed, so LIMIT-1 marks the final one.
  assign expire_o = en_i && (count_r >= LAST);

endmodule

// File: rtl/support_wb_sequencer.sv
// Sequences support-CPU I/O cycles onto the shared Wishbone peripheral bus.
// Optional strobe timeout is enabled with `define SUPPORT_WB_TIMEOUT_EN.
module support_wb_sequencer
  import support_io_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] TIMEOUT_DATA   = 8'hFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   iorq_n_i,
  input  logic                   rd_n_i,
  input  logic                   wr_n_i,
  input  logic [7:0]             addr_i,
  input  logic [7:0]             dat_i,
  output logic [7:0]             dat_o,
  output logic                   wait_n_o,
  output logic [7:0]             wb_adr_o,
  output logic [7:0]             wb_dat_o,
  input  logic [7:0]             wb_dat_i,
  output logic                   wb_we_o,
  output logic                   wb_cyc_o,
  output logic [STB_DEVICES-1:0] wb_stb_o,
  input  logic                   wb_ack_i,
  output logic                   timeout_o,
  output logic                   busy_o
);

  seq_state_t             state_r, state_nx_s;
  logic                   req_s, start_s, expire_s, wait_n_s;
  logic [7:0]             adr_r, wdat_r, dat_r;
  logic                   we_r, cyc_r, to_r, busy_r;
  logic [STB_DEVICES-1:0] stb_r;

  // An IORQ without RD or WR is an interrupt acknowledge, not a bus request.
  assign req_s   = !iorq_n_i && (!rd_n_i || !wr_n_i);
  assign start_s = (state_r == ST_IDLE) && req_s;

`ifdef SUPPORT_WB_TIMEOUT_EN
  wb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start_s),
    .en_i    (state_r == ST_STROBE),
    .expire_o(expire_s)
  );
`else
  // Constant false for every legal TIMEOUT_CYCLES; STROBE waits for ack forever.
  assign expire_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state decode for the I/O cycle sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_DISARMED: if (iorq_n_i) state_nx_s = ST_IDLE;   else state_nx_s = ST_DISARMED;
      ST_IDLE:     if (req_s)    state_nx_s = ST_STROBE; else state_nx_s = ST_IDLE;
      ST_STROBE: begin
        if (wb_ack_i || expire_s) state_nx_s = ST_HOLD;
        else                      state_nx_s = ST_STROBE;
      end
      ST_HOLD:     if (iorq_n_i) state_nx_s = ST_IDLE;   else state_nx_s = ST_HOLD;
      default:     state_nx_s = ST_DISARMED;
    endcase
  end

  // CPU wait: stalls from the first cycle a request is visible until the strobe ends.
  always_comb begin
    wait_n_s = 1'b1;
    case (state_r)
      ST_STROBE: wait_n_s = 1'b0;
      ST_IDLE:   if (req_s) wait_n_s = 1'b0; else wait_n_s = 1'b1;
      default:   wait_n_s = 1'b1;
    endcase
  end

  // State register; reset lands in DISARMED so an in-flight CPU cycle is never issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_DISARMED;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Registered bus outputs, latched request fields and CPU read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_r  <= RST_ADR;
      wdat_r <= RST_DAT;
      dat_r  <= RST_DAT;
      we_r   <= 1'b0;
      cyc_r  <= 1'b0;
      stb_r  <= RST_STB;
      to_r   <= 1'b0;
      busy_r <= 1'b1;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      cyc_r  <= (state_nx_s == ST_STROBE);
      to_r   <= (state_r == ST_STROBE) && expire_s && !wb_ack_i;
      if (start_s) begin
        adr_r  <= addr_i;
        wdat_r <= dat_i;
        we_r   <= !wr_n_i;
        stb_r  <= stb_decode(addr_i[7:4]);
      end else if (state_nx_s != ST_STROBE) begin
        stb_r  <= RST_STB;
      end
      // Ack takes priority over a coincident timeout.
      if ((state_r == ST_STROBE) && !we_r) begin
        if (wb_ack_i) begin
          dat_r <= wb_dat_i;
        end else if (expire_s) begin
          dat_r <= TIMEOUT_DATA;
        end
      end
    end
  end

  assign dat_o     = dat_r;
  assign wait_n_o  = wait_n_s;
  assign wb_adr_o  = adr_r;
  assign wb_dat_o  = wdat_r;
  assign wb_we_o   = we_r;
  assign wb_cyc_o  = cyc_r;
  assign wb_stb_o  = stb_r;
  assign timeout_o = to_r;
  assign busy_o    = busy_r;

endmodule
